// File: rtl/complex_issue_sched_if.sv
// Bundle between the complex RS pair / writeback port and the complex issue scheduler.
// master = RS/ROB side, slave = scheduler.
interface complex_issue_sched_if #(
   parameter int ROB_W = 4
);
   logic             flush;
   logic             rs0_ready;
   logic [5:0]       rs0_aluop;
   logic [ROB_W-1:0] rs0_rob;
   logic             rs1_ready;
   logic [5:0]       rs1_aluop;
   logic [ROB_W-1:0] rs1_rob;
   logic             rs0_older;
   logic             wb_ready;
   logic             issue0;
   logic             issue1;
   logic             exu_sel;
   logic             exu_start;
   logic             busy;
   logic             done_valid;
   logic [ROB_W-1:0] done_rob;

   modport master (
      output flush, rs0_ready, rs0_aluop, rs0_rob, rs1_ready, rs1_aluop, rs1_rob,
             rs0_older, wb_ready,
      input  issue0, issue1, exu_sel, exu_start, busy, done_valid, done_rob
   );

   modport slave (
      input  flush, rs0_ready, rs0_aluop, rs0_rob, rs1_ready, rs1_aluop, rs1_rob,
             rs0_older, wb_ready,
      output issue0, issue1, exu_sel, exu_start, busy, done_valid, done_rob
   );
endinterface

// File: rtl/complex_issue_sched.sv
// Complex-unit issue scheduler: picks one of two RS entries, sequences MUL/DIV latency,
// holds a registered completion for writeback. COMPLEX_SCHED_PERF_EN adds perf counters.
module complex_issue_sched #(
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 8,
   parameter int ROB_W   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   complex_issue_sched_if.slave bus
`ifdef COMPLEX_SCHED_PERF_EN
   ,
   output logic [31:0]          perf_issue_cnt,
   output logic [31:0]          perf_stall_cnt
`endif
);
   typedef enum logic {IDLE, BUSY} state_t;

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [ROB_W-1:0] rob_q;
   logic             done_v;
   logic [ROB_W-1:0] done_r;

   logic             wb_free, can_issue, pick0, pick1;
   logic [1:0]       sel_cls;
   logic [ROB_W-1:0] sel_rob;
   logic             unused_aluop_lo;

   assign unused_aluop_lo = ^{bus.rs0_aluop[3:0], bus.rs1_aluop[3:0]};

   always_comb begin
      wb_free   = !done_v || bus.wb_ready;
      can_issue = (state == IDLE) && !bus.flush && wb_free;
      pick0     = can_issue && bus.rs0_ready && (!bus.rs1_ready || bus.rs0_older);
      pick1     = can_issue && bus.rs1_ready && !pick0;
      sel_cls   = pick1 ? bus.rs1_aluop[5:4] : bus.rs0_aluop[5:4];
      sel_rob   = pick1 ? bus.rs1_rob : bus.rs0_rob;
   end

   assign bus.issue0     = pick0;
   assign bus.issue1     = pick1;
   assign bus.exu_sel    = pick1;
   assign bus.exu_start  = pick0 | pick1;
   assign bus.busy       = (state == BUSY);
   assign bus.done_valid = done_v;
   assign bus.done_rob   = done_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         rob_q  <= '0;
         done_v <= 1'b0;
         done_r <= '0;
      end else if (bus.flush) begin
         state  <= IDLE;
         cnt    <= '0;
         done_v <= 1'b0;
      end else begin
         // acceptance clears done_v; a completion loaded below in the same cycle wins
         if (done_v && bus.wb_ready) done_v <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pick0 || pick1) begin
                  if (sel_cls[1]) begin
                     state <= BUSY;
                     rob_q <= sel_rob;
                     cnt   <= sel_cls[0] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
                  end else begin
                     done_v <= 1'b1;
                     done_r <= sel_rob;
                  end
               end
            end
            BUSY: begin
               if (cnt != CNT_W'(1)) begin
                  cnt <= cnt - CNT_W'(1);
               end else if (wb_free) begin
                  done_v <= 1'b1;
                  done_r <= rob_q;
                  state  <= IDLE;
                  cnt    <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef COMPLEX_SCHED_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_issue_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (pick0 || pick1) perf_issue_cnt <= perf_issue_cnt + 32'd1;
         if ((bus.rs0_ready || bus.rs1_ready) && !(pick0 || pick1))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_complex_issue_sched.sv
// Directed self-checking bench for complex_issue_sched (default MUL_LAT=3, DIV_LAT=8).
module tb_complex_issue_sched;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   complex_issue_sched_if #(.ROB_W(4)) bus ();

`ifdef COMPLEX_SCHED_PERF_EN
   logic [31:0] perf_issue_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   complex_issue_sched #(.MUL_LAT(3), .DIV_LAT(8), .ROB_W(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus)
`ifdef COMPLEX_SCHED_PERF_EN
      ,
      .perf_issue_cnt (perf_issue_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.flush     = 1'b0;
      bus.rs0_ready = 1'b0;
      bus.rs0_aluop = 6'd0;
      bus.rs0_rob   = 4'd0;
      bus.rs1_ready = 1'b0;
      bus.rs1_aluop = 6'd0;
      bus.rs1_rob   = 4'd0;
      bus.rs0_older = 1'b0;
      bus.wb_ready  = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (bus.issue0 !== 1'b0) begin errors++; $display("FAIL reset_issue0 got %0b exp 0", bus.issue0); end
      checks++; if (bus.issue1 !== 1'b0) begin errors++; $display("FAIL reset_issue1 got %0b exp 0", bus.issue1); end
      checks++; if (bus.exu_sel !== 1'b0) begin errors++; $display("FAIL reset_exu_sel got %0b exp 0", bus.exu_sel); end
      checks++; if (bus.exu_start !== 1'b0) begin errors++; $display("FAIL reset_exu_start got %0b exp 0", bus.exu_start); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
      checks++; if (bus.done_valid !== 1'b0) begin errors++; $display("FAIL reset_done_valid got %0b exp 0", bus.done_valid); end
      checks++; if (bus.done_rob !== 4'd0) begin errors++; $display("FAIL reset_done_rob got %0d exp 0", bus.done_rob); end
   endtask

   task automatic test_both_single();
      bus.rs0_ready = 1'b1; bus.rs0_aluop = 6'd0;  bus.rs0_rob = 4'd3;
      bus.rs1_ready = 1'b1; bus.rs1_aluop = 6'h05; bus.rs1_rob = 4'd5;
      bus.rs0_older = 1'b0; bus.wb_ready = 1'b1;
      #1;
      checks++; if (bus.issue1 !== 1'b1) begin errors++; $display("FAIL both_issue1 got %0b exp 1", bus.issue1); end
      checks++; if (bus.issue0 !== 1'b0) begin errors++; $display("FAIL both_issue0 got %0b exp 0", bus.issue0); end
      checks++; if (bus.exu_sel !== 1'b1) begin errors++; $display("FAIL both_exu_sel got %0b exp 1", bus.exu_sel); end
      checks++; if (bus.exu_start !== 1'b1) begin errors++; $display("FAIL both_exu_start got %0b exp 1", bus.exu_start); end
      tick();
      checks++; if (bus.done_valid !== 1'b1) begin errors++; $display("FAIL both_done_valid got %0b exp 1", bus.done_valid); end
      checks++; if (bus.done_rob !== 4'd5) begin errors++; $display("FAIL both_done_rob got %0d exp 5", bus.done_rob); end
      bus.rs0_older = 1'b1;
      #1;
      checks++; if (bus.issue0 !== 1'b1) begin errors++; $display("FAIL older_issue0 got %0b exp 1", bus.issue0); end
      checks++; if (bus.exu_sel !== 1'b0) begin errors++; $display("FAIL older_exu_sel got %0b exp 0", bus.exu_sel); end
      tick();
      checks++; if (bus.done_rob !== 4'd3) begin errors++; $display("FAIL older_done_rob got %0d exp 3", bus.done_rob); end
      bus.rs0_ready = 1'b0;
      #1;
      checks++; if (bus.issue1 !== 1'b1) begin errors++; $display("FAIL only1_issue1 got %0b exp 1", bus.issue1); end
      tick();
      checks++; if (bus.done_rob !== 4'd5) begin errors++; $display("FAIL only1_done_rob got %0d exp 5", bus.done_rob); end
      bus.rs1_ready = 1'b0;
      tick();
      checks++; if (bus.done_valid !== 1'b0) begin errors++; $display("FAIL both_done_clear got %0b exp 0", bus.done_valid); end
   endtask

   task automatic test_mul_latency();
      bus.rs0_ready = 1'b1; bus.rs0_aluop = 6'b100000; bus.rs0_rob = 4'd11;
      #1;
      checks++; if (bus.issue0 !== 1'b1) begin errors++; $display("FAIL mul_issue0 got %0b exp 1", bus.issue0); end
      tick();
      bus.rs0_ready = 1'b0;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mul_busy_t1 got %0b exp 1", bus.busy); end
      tick();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mul_busy_t2 got %0b exp 1", bus.busy); end
      checks++; if (bus.done_valid !== 1'b0) begin errors++; $display("FAIL mul_early_done got %0b exp 0", bus.done_valid); end
      tick();
      checks++; if (bus.done_valid !== 1'b1) begin errors++; $display("FAIL mul_done_valid got %0b exp 1", bus.done_valid); end
      checks++; if (bus.done_rob !== 4'd11) begin errors++; $display("FAIL mul_done_rob got %0d exp 11", bus.done_rob); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mul_busy_end got %0b exp 0", bus.busy); end
      tick();
      checks++; if (bus.done_valid !== 1'b0) begin errors++; $display("FAIL mul_done_clear got %0b exp 0", bus.done_valid); end
   endtask

   task automatic test_div_latency();
      bus.rs0_ready = 1'b1; bus.rs0_aluop = 6'b110000; bus.rs0_rob = 4'd7;
      #1;
      checks++; if (bus.issue0 !== 1'b1) begin errors++; $display("FAIL div_issue0 got %0b exp 1", bus.issue0); end
      tick();
      bus.rs0_ready = 1'b0;
      bus.rs1_ready = 1'b1; bus.rs1_aluop = 6'd0; bus.rs1_rob = 4'd2;
      for (int k = 1; k <= 7; k++) begin
         #1;
         checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL div_busy t+%0d got %0b exp 1", k, bus.busy); end
         checks++; if (bus.issue1 !== 1'b0) begin errors++; $display("FAIL div_no_issue t+%0d got %0b exp 0", k, bus.issue1); end
         checks++; if (bus.done_valid !== 1'b0) begin errors++; $display("FAIL div_early_done t+%0d got %0b exp 0", k, bus.done_valid); end
         tick();
      end
      checks++; if (bus.done_valid !== 1'b1) begin errors++; $display("FAIL div_done_valid got %0b exp 1", bus.done_valid); end
      checks++; if (bus.done_rob !== 4'd7) begin errors++; $display("FAIL div_done_rob got %0d exp 7", bus.done_rob); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL div_busy_end got %0b exp 0", bus.busy); end
      #1;
      checks++; if (bus.issue1 !== 1'b1) begin errors++; $display("FAIL div_resume_issue1 got %0b exp 1", bus.issue1); end
      tick();
      bus.rs1_ready = 1'b0;
      checks++; if (bus.done_rob !== 4'd2) begin errors++; $display("FAIL div_next_rob got %0d exp 2", bus.done_rob); end
      tick();
      checks++; if (bus.done_valid !== 1'b0) begin errors++; $display("FAIL div_done_clear got %0b exp 0", bus.done_valid); end
   endtask

   task automatic test_backpressure();
      bus.wb_ready = 1'b0;
      bus.rs0_ready = 1'b1; bus.rs0_aluop = 6'b010000; bus.rs0_rob = 4'd9;
      #1;
      checks++; if (bus.issue0 !== 1'b1) begin errors++; $display("FAIL bp_first_issue got %0b exp 1", bus.issue0); end
      tick();
      bus.rs0_rob = 4'd10;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if (bus.done_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid c%0d got %0b exp 1", k, bus.done_valid); end
         checks++; if (bus.done_rob !== 4'd9) begin errors++; $display("FAIL bp_hold_rob c%0d got %0d exp 9", k, bus.done_rob); end
         checks++; if (bus.issue0 !== 1'b0) begin errors++; $display("FAIL bp_no_issue c%0d got %0b exp 0", k, bus.issue0); end
         tick();
      end
      bus.wb_ready = 1'b1;
      #1;
      checks++; if (bus.issue0 !== 1'b1) begin errors++; $display("FAIL bp_resume_issue got %0b exp 1", bus.issue0); end
      tick();
      bus.rs0_ready = 1'b0;
      checks++; if (bus.done_valid !== 1'b1) begin errors++; $display("FAIL bp_swap_valid got %0b exp 1", bus.done_valid); end
      checks++; if (bus.done_rob !== 4'd10) begin errors++; $display("FAIL bp_swap_rob got %0d exp 10", bus.done_rob); end
      tick();
      checks++; if (bus.done_valid !== 1'b0) begin errors++; $display("FAIL bp_done_clear got %0b exp 0", bus.done_valid); end
   endtask

   task automatic test_flush();
      bus.flush = 1'b1;
      bus.rs0_ready = 1'b1; bus.rs0_aluop = 6'd0; bus.rs0_rob = 4'd1;
      #1;
      checks++; if (bus.issue0 !== 1'b0) begin errors++; $display("FAIL flush_idle_issue got %0b exp 0", bus.issue0); end
      checks++; if (bus.exu_start !== 1'b0) begin errors++; $display("FAIL flush_idle_start got %0b exp 0", bus.exu_start); end
      tick();
      bus.flush = 1'b0; bus.rs0_ready = 1'b0;
      checks++; if (bus.done_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_done got %0b exp 0", bus.done_valid); end
      // flush drops a completion held under backpressure
      bus.wb_ready = 1'b0;
      bus.rs0_ready = 1'b1; bus.rs0_rob = 4'd12;
      tick();
      bus.rs0_ready = 1'b0;
      checks++; if (bus.done_valid !== 1'b1) begin errors++; $display("FAIL flush_held_pre got %0b exp 1", bus.done_valid); end
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0; bus.wb_ready = 1'b1;
      checks++; if (bus.done_valid !== 1'b0) begin errors++; $display("FAIL flush_held_drop got %0b exp 0", bus.done_valid); end
      // flush one cycle after a MUL issue
      bus.rs0_ready = 1'b1; bus.rs0_aluop = 6'b100000; bus.rs0_rob = 4'd4;
      #1;
      checks++; if (bus.issue0 !== 1'b1) begin errors++; $display("FAIL flush_mul_issue got %0b exp 1", bus.issue0); end
      tick();
      bus.rs0_ready = 1'b0; bus.flush = 1'b1;
      bus.rs1_ready = 1'b1; bus.rs1_aluop = 6'd0; bus.rs1_rob = 4'd6;
      #1;
      checks++; if (bus.issue1 !== 1'b0) begin errors++; $display("FAIL flush_mul_noissue got %0b exp 0", bus.issue1); end
      tick();
      bus.flush = 1'b0;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_mul_busy got %0b exp 0", bus.busy); end
      checks++; if (bus.done_valid !== 1'b0) begin errors++; $display("FAIL flush_mul_done got %0b exp 0", bus.done_valid); end
      #1;
      checks++; if (bus.issue1 !== 1'b1) begin errors++; $display("FAIL flush_mul_reissue got %0b exp 1", bus.issue1); end
      tick();
      bus.rs1_ready = 1'b0;
      checks++; if (bus.done_rob !== 4'd6) begin errors++; $display("FAIL flush_mul_newrob got %0d exp 6", bus.done_rob); end
      tick();
      tick();
      checks++; if (bus.done_valid !== 1'b0) begin errors++; $display("FAIL flush_mul_ghost got %0b exp 0", bus.done_valid); end
   endtask

   task automatic test_reset_mid();
      bus.rs0_ready = 1'b1; bus.rs0_aluop = 6'b110000; bus.rs0_rob = 4'd13;
      tick();
      bus.rs0_ready = 1'b0;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre got %0b exp 1", bus.busy); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_async got %0b exp 0", bus.busy); end
      tick();
      rst = 1'b0;
      repeat (9) tick();
      checks++; if (bus.done_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ghost got %0b exp 0", bus.done_valid); end
   endtask

`ifdef COMPLEX_SCHED_PERF_EN
   task automatic test_perf();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (perf_issue_cnt !== 32'd0) begin errors++; $display("FAIL perf_issue_reset got %0d exp 0", perf_issue_cnt); end
      bus.wb_ready = 1'b1;
      bus.rs0_ready = 1'b1; bus.rs0_aluop = 6'd0;
      for (int i = 0; i < 4; i++) begin
         bus.rs0_rob = 4'(i);
         tick();
      end
      bus.rs0_aluop = 6'b110000;
      tick();
      bus.rs0_ready = 1'b0;
      bus.rs1_ready = 1'b1; bus.rs1_aluop = 6'd0;
      repeat (6) tick();
      bus.rs1_ready = 1'b0;
      repeat (3) tick();
      checks++; if (perf_issue_cnt !== 32'd5) begin errors++; $display("FAIL perf_issue_cnt got %0d exp 5", perf_issue_cnt); end
      checks++; if (perf_stall_cnt !== 32'd6) begin errors++; $display("FAIL perf_stall_cnt got %0d exp 6", perf_stall_cnt); end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      clk = 1'b0;
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      test_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      test_both_single();
      test_mul_latency();
      test_div_latency();
      test_backpressure();
      test_flush();
      test_reset_mid();
`ifdef COMPLEX_SCHED_PERF_EN
      test_perf();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/complex_issue_sched.md
Name: complex_issue_sched

Overview:
- Issue scheduler for the complex execution unit. Each cycle it picks at most one of the two complex reservation-station entries and drives the operand mux select.
- Sequences multi-cycle MUL/DIV operations with a latency counter.
- Presents a registered completion (ROB index) to writeback with ready/valid backpressure.
- Sits between the complex RS pair and the complex ALU/ROB write port.

Parameters:
- MUL_LAT, 3, total cycles from issue to result for MUL-class ops (>=2)
- DIV_LAT, 8, total cycles from issue to result for DIV-class ops (>=2)
- ROB_W, 4, ROB index width

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  pipeline flush (synchronous)
- rs0_ready  in  1  RS entry 0 valid with both operands ready
- rs0_aluop  in  6  RS entry 0 aluop
- rs0_rob  in  ROB_W  RS entry 0 ROB index
- rs1_ready  in  1  RS entry 1 valid with both operands ready
- rs1_aluop  in  6  RS entry 1 aluop
- rs1_rob  in  ROB_W  RS entry 1 ROB index
- rs0_older  in  1  1 = entry 0 is the older instruction
- wb_ready  in  1  ROB/RF write port accepts completion this cycle
- issue0  out  1  one-cycle pulse: entry 0 consumed
- issue1  out  1  one-cycle pulse: entry 1 consumed
- exu_sel  out  1  operand mux select (0 = entry 0, 1 = entry 1), valid with issue
- exu_start  out  1  = issue0|issue1
- busy  out  1  multi-cycle op in flight
- done_valid  out  1  registered completion valid
- done_rob  out  ROB_W  ROB index of the completing op

Behaviour:
- Reset: state IDLE; counter 0; done_valid 0; done_rob 0; busy 0; issue0/issue1/exu_start 0; exu_sel 0.
- Op class from aluop[5:4]:
  - 2'b10 = MUL
  - 2'b11 = DIV
  - otherwise SINGLE (1-cycle)
- Issue permitted (can_issue) when state==IDLE, flush==0, and (done_valid==0 or wb_ready==1).
- Selection when can_issue:
  - Only rs0_ready: pick entry 0.
  - Only rs1_ready: pick entry 1.
  - Both ready: pick entry 0 if rs0_older else entry 1.
  - Neither ready: no issue.
  - issue0/issue1 are combinational, mutually exclusive, never both high.
- SINGLE issue at cycle t:
  - done_valid=1 and done_rob=selected rob at t+1.
  - Back-to-back single issues allowed while wb_ready stays high (throughput 1/cycle).
- MUL/DIV issue at cycle t:
  - Latch rob; counter loads LAT-1; state goes to BUSY; busy=1 from t+1.
- BUSY state:
  - No issue.
  - Counter decrements each cycle unless it is 1 while done_valid is held with wb_ready==0; in that case it stalls at 1.
  - When counter==1 and (done_valid==0 or wb_ready): next cycle sets done_valid=1 and done_rob=latched rob, returns to IDLE, busy=0.
  - Result: done_valid first asserts exactly LAT cycles after issue when unstalled.
- done_valid hold: stays high with stable done_rob until wb_ready; clears the cycle after acceptance unless a new completion is loaded in the same cycle.
- Simultaneous events: wb_ready acceptance and a new completion load in the same cycle leave done_valid high with the new done_rob.
- flush:
  - Next cycle: state IDLE, counter 0, busy 0, done_valid 0.
  - No issue pulse in the flush cycle.
  - Flush overrides all other events.
- rst asserted mid-operation returns all state to reset values immediately.

Optional Feature:
- Macro COMPLEX_SCHED_PERF_EN.
- Defined: adds outputs perf_issue_cnt[31:0] (increments per issue pulse) and perf_stall_cnt[31:0] (increments each cycle any rs*_ready is high but no issue occurs). Both counters reset to 0 on rst, are unaffected by flush, and wrap at 2^32.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst pulse, no ready -> all outputs 0, state IDLE.
- Both ready, SINGLE ops: rs0_ready=rs1_ready=1, rs0_older=0, rs0_rob=3, rs1_rob=5, wb_ready=1 -> issue1=1, exu_sel=1 at t; done_valid=1, done_rob=5 at t+1.
- DIV latency: rs0_ready, aluop=6'b110000, rs0_rob=7 at t, wb_ready=1 -> busy t+1..t+7, no issue during busy despite rs1_ready, done_valid=1 with done_rob=7 at t+8.
- Backpressure: SINGLE issue with wb_ready=0 for 4 cycles -> done_valid held with constant done_rob, no new issue until wb_ready=1, then issue resumes in that same cycle.
- Flush mid-MUL: MUL issued at t, flush at t+1 -> busy=0 and done_valid=0 at t+2, no completion for that rob; new issue allowed at t+2.
- Perf (COMPLEX_SCHED_PERF_EN): 5 issues plus 6 busy cycles with rs1_ready=1 -> perf_issue_cnt=5, perf_stall_cnt=6.
